qspi_req_arbiter: RTL

QSPI_REQ_ARBITER -- requirements
Module: qspi_req_arbiter

---
 rtl/qspi_req_arbiter_if.sv | 59 +++++
 rtl/qspi_req_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/qspi_req_arbiter_if.sv
// Signal bundle between two requesting masters, the arbiter and the single
// downstream QSPI request port.
interface qspi_req_arbiter_if;
   logic        m0_read_req;
   logic        m0_write_req;
   logic        m0_w;
   logic        m0_hw;
   logic [31:0] m0_adr;
   logic [31:0] m0_wdata;
   logic [31:0] m0_rdata;
   logic        m0_read_valid;
   logic        m0_write_finish;
   logic        m0_err;

   logic        m1_read_req;
   logic        m1_write_req;
   logic        m1_w;
   logic        m1_hw;
   logic [31:0] m1_adr;
   logic [31:0] m1_wdata;
   logic [31:0] m1_rdata;
   logic        m1_read_valid;
   logic        m1_write_finish;
   logic        m1_err;

   logic        read_req;
   logic        read_w;
   logic        read_hw;
   logic [31:0] read_adr;
   logic        write_req;
   logic        write_w;
   logic        write_hw;
   logic [31:0] write_adr;
   logic [31:0] write_data;
   logic        read_valid;
   logic [31:0] read_data;
   logic        write_finish;

   // Arbiter side: consumes master requests, drives the QSPI request port.
   modport slave (
      input  m0_read_req, m0_write_req, m0_w, m0_hw, m0_adr, m0_wdata,
      output m0_rdata, m0_read_valid, m0_write_finish, m0_err,
      input  m1_read_req, m1_write_req, m1_w, m1_hw, m1_adr, m1_wdata,
      output m1_rdata, m1_read_valid, m1_write_finish, m1_err,
      output read_req, read_w, read_hw, read_adr,
      output write_req, write_w, write_hw, write_adr, write_data,
      input  read_valid, read_data, write_finish
   );

   modport master (
      output m0_read_req, m0_write_req, m0_w, m0_hw, m0_adr, m0_wdata,
      input  m0_rdata, m0_read_valid, m0_write_finish, m0_err,
      output m1_read_req, m1_write_req, m1_w, m1_hw, m1_adr, m1_wdata,
      input  m1_rdata, m1_read_valid, m1_write_finish, m1_err,
      input  read_req, read_w, read_hw, read_adr,
      input  write_req, write_w, write_hw, write_adr, write_data,
      output read_valid, read_data, write_finish
   );
endinterface

// File: rtl/qspi_req_arbiter.sv
// Two-master arbiter in front of a single-outstanding QSPI request port,
// with an optional per-transaction timeout abort.
module qspi_req_arbiter #(
   parameter int FIXED_PRIO = 0,
   parameter int TMO_W      = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   qspi_req_arbiter_if.slave bus,
   input  logic [TMO_W-1:0]  tmo_limit,
   output logic              busy,
   output logic              grant
);
   typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
   state_t state_reg, state_next;

   logic [1:0]       rd_req, wr_req, any_req, w_in, hw_in;
   logic [31:0]      adr_in   [2];
   logic [31:0]      wdata_in [2];

   logic [31:0]      adr_reg, wdata_reg;
   logic             w_reg, hw_reg;
   logic             grant_reg, last_grant_reg;
   logic [TMO_W-1:0] tmo_cnt_reg;

   logic winner, take_grant, rd_done, wr_done, rd_abort, wr_abort, tmo_hit;

   assign rd_req      = {bus.m1_read_req,  bus.m0_read_req};
   assign wr_req      = {bus.m1_write_req, bus.m0_write_req};
   assign w_in        = {bus.m1_w,  bus.m0_w};
   assign hw_in       = {bus.m1_hw, bus.m0_hw};
   assign adr_in[0]   = bus.m0_adr;
   assign adr_in[1]   = bus.m1_adr;
   assign wdata_in[0] = bus.m0_wdata;
   assign wdata_in[1] = bus.m1_wdata;
   assign any_req     = rd_req | wr_req;

   // Ties go to m0 in fixed mode, otherwise to whoever was not served last.
   always_comb begin
      winner = any_req[1];
      if (any_req == 2'b11)
         winner = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_reg;
   end

   // Counter holds the number of completed RD/WR cycles; this is the last one.
   assign tmo_hit = (tmo_limit != '0) && (tmo_cnt_reg == tmo_limit - TMO_W'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      take_grant = 1'b0;
      rd_done    = 1'b0;
      wr_done    = 1'b0;
      rd_abort   = 1'b0;
      wr_abort   = 1'b0;
      case (state_reg)
         IDLE: if (any_req != 2'b00) begin
            take_grant = 1'b1;
            state_next = rd_req[winner] ? RD : WR;
         end
         RD: if (bus.read_valid) begin
            rd_done    = 1'b1;
            state_next = DONE;
         end else if (tmo_hit) begin
            rd_abort   = 1'b1;
            state_next = DONE;
         end
         WR: if (bus.write_finish) begin
            wr_done    = 1'b1;
            state_next = DONE;
         end else if (tmo_hit) begin
            wr_abort   = 1'b1;
            state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adr_reg        <= '0;
         wdata_reg      <= '0;
         w_reg          <= 1'b0;
         hw_reg         <= 1'b0;
         grant_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         tmo_cnt_reg    <= '0;
      end else if (take_grant) begin
         adr_reg        <= adr_in[winner];
         wdata_reg      <= wdata_in[winner];
         w_reg          <= w_in[winner];
         hw_reg         <= hw_in[winner];
         grant_reg      <= winner;
         last_grant_reg <= winner;
         tmo_cnt_reg    <= '0;
      end else if (state_reg == RD || state_reg == WR) begin
         tmo_cnt_reg    <= tmo_cnt_reg + TMO_W'(1);
      end
   end

   // Completion registers per master; only the granted one ever changes.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_master
         logic        mine;
         logic [31:0] rdata_reg;
         logic        read_valid_reg, write_finish_reg, err_reg;

         assign mine = (grant_reg == 1'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rdata_reg        <= '0;
               read_valid_reg   <= 1'b0;
               write_finish_reg <= 1'b0;
               err_reg          <= 1'b0;
            end else begin
               read_valid_reg   <= mine && (rd_done || rd_abort);
               write_finish_reg <= mine && (wr_done || wr_abort);
               err_reg          <= mine && (rd_abort || wr_abort);
               if (mine && rd_done)
                  rdata_reg <= bus.read_data;
               else if (mine && rd_abort)
                  rdata_reg <= '0;
            end
         end
      end
   endgenerate

   assign bus.m0_rdata        = g_master[0].rdata_reg;
   assign bus.m0_read_valid   = g_master[0].read_valid_reg;
   assign bus.m0_write_finish = g_master[0].write_finish_reg;
   assign bus.m0_err          = g_master[0].err_reg;
   assign bus.m1_rdata        = g_master[1].rdata_reg;
   assign bus.m1_read_valid   = g_master[1].read_valid_reg;
   assign bus.m1_write_finish = g_master[1].write_finish_reg;
   assign bus.m1_err          = g_master[1].err_reg;

   assign bus.read_req   = (state_reg == RD);
   assign bus.read_w     = w_reg;
   assign bus.read_hw    = hw_reg;
   assign bus.read_adr   = adr_reg;
   assign bus.write_req  = (state_reg == WR);
   assign bus.write_w    = w_reg;
   assign bus.write_hw   = hw_reg;
   assign bus.write_adr  = adr_reg;
   assign bus.write_data = wdata_reg;

   assign busy  = (state_reg != IDLE);
   assign grant = grant_reg;
endmodule
